// File: rtl/instr_register_alu.sv
// Instruction register: 32-entry store of {opcode, operand_a, operand_b, result}.
// Results come from a two-stage write pipeline, and reads go through a registered port.
// Optional macro INSTR_REG_BYPASS_EN forwards the in-flight stage-1 word to a matching read.
module instr_register_alu (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic [31:0]  operand_a,
  input  logic [31:0]  operand_b,
  input  logic [3:0]   opcode,
  input  logic [4:0]   write_pointer,
  input  logic [4:0]   read_pointer,
  output logic [104:0] instruction_word,
  output logic         rd_valid
);

  localparam int unsigned OP_WIDTH   = 32;
  localparam int unsigned OPC_WIDTH  = 4;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned RES_WIDTH  = 32;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam int unsigned WORD_WIDTH = 105;
  localparam int unsigned PAD_WIDTH  = WORD_WIDTH - OPC_WIDTH - 2 * OP_WIDTH - RES_WIDTH;

  typedef logic signed [OP_WIDTH-1:0]  operand_t;
  typedef logic signed [RES_WIDTH-1:0] result_t;
  typedef logic [ADDR_WIDTH-1:0]       address_t;
  typedef enum logic [OPC_WIDTH-1:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef struct packed {
    logic [OPC_WIDTH-1:0] opc;
    operand_t             op_a;
    operand_t             op_b;
    result_t              res;
  } instruction_t;

  localparam operand_t INT_MIN = {1'b1, {(OP_WIDTH-1){1'b0}}};

  instruction_t mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic         s1_valid;
  address_t     s1_ptr;
  instruction_t s1_word;
  instruction_t commit_word;
  instruction_t rd_word;
  logic         rd_hit;

  // Signed 32b arithmetic that wraps; divide-by-zero and any undefined opcode yield 0.
  function automatic result_t alu(input logic [OPC_WIDTH-1:0] opc,
                                  input operand_t a, input operand_t b);
    result_t r;
    r = '0;
    case (opcode_t'(opc))
      ZERO:  r = '0;
      PASSA: r = a;
      PASSB: r = b;
      ADD:   r = a + b;
      SUB:   r = a - b;
      MULT:  r = a * b;
      DIV: begin
        if (b == '0)                    r = '0;
        else if (a == INT_MIN && b == '1) r = INT_MIN;
        else                            r = a / b;
      end
      MOD: begin
        if (b == '0 || (a == INT_MIN && b == '1)) r = '0;
        else                                      r = a % b;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    commit_word     = s1_word;
    commit_word.res = alu(s1_word.opc, s1_word.op_a, s1_word.op_b);
  end

  always_comb begin
    rd_word = mem[read_pointer];
    rd_hit  = valid[read_pointer];
`ifdef INSTR_REG_BYPASS_EN
    if (s1_valid && s1_ptr == read_pointer) begin
      rd_word = commit_word;
      rd_hit  = 1'b1;
    end
`endif
  end

  // Capture in stage 1, commit to storage one edge later, and read the pre-edge storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid         <= 1'b0;
      s1_ptr           <= '0;
      s1_word          <= '0;
      valid            <= '0;
      instruction_word <= '0;
      rd_valid         <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      s1_valid <= load_en;
      if (load_en) begin
        s1_ptr       <= write_pointer;
        s1_word.opc  <= opcode;
        s1_word.op_a <= operand_a;
        s1_word.op_b <= operand_b;
        s1_word.res  <= '0;
      end
      if (s1_valid) begin
        mem[s1_ptr]   <= commit_word;
        valid[s1_ptr] <= 1'b1;
      end
      instruction_word <= {PAD_WIDTH'(0), rd_word};
      rd_valid         <= rd_hit;
    end
  end

endmodule

// File: tb/tb_instr_register_alu.sv
// Randomized self-checking bench for instr_register_alu against a write-history model.
module tb_instr_register_alu;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_en;
  logic [31:0]  operand_a;
  logic [31:0]  operand_b;
  logic [3:0]   opcode;
  logic [4:0]   write_pointer;
  logic [4:0]   read_pointer;
  logic [104:0] instruction_word;
  logic         rd_valid;

  instr_register_alu dut (
    .clk              (clk),
    .reset            (reset),
    .load_en          (load_en),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .opcode           (opcode),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .rd_valid         (rd_valid)
  );

  always #5 clk = ~clk;

`ifdef INSTR_REG_BYPASS_EN
  localparam int VIS_LAT = 1;
`else
  localparam int VIS_LAT = 2;
`endif

  typedef struct {
    int           cyc;
    logic [4:0]   addr;
    logic [104:0] word;
  } wr_t;

  wr_t log_q[$];
  int  cyc    = 0;
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string tag, input logic [104:0] got, input logic [104:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_res(input logic [3:0] opc, input int a, input int b);
    longint la = longint'(a);
    longint lb = longint'(b);
    case (opc)
      4'd0: return 0;
      4'd1: return a;
      4'd2: return b;
      4'd3: return int'(la + lb);
      4'd4: return int'(la - lb);
      4'd5: return int'(la * lb);
      4'd6: return (b == 0) ? 0 : int'(la / lb);
      4'd7: return (b == 0) ? 0 : int'(la % lb);
      default: return 0;
    endcase
  endfunction

  function automatic logic [104:0] mk_word(input logic [3:0] opc, input int a, input int b);
    int r = model_res(opc, a, b);
    return {5'd0, opc, a, b, r};
  endfunction

  // A write captured at cycle N is seen by reads sampled at N+VIS_LAT or later; latest wins.
  task automatic expect_read(input int rc, input logic [4:0] addr,
                             output logic [104:0] w, output logic v);
    w = '0;
    v = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].addr == addr && log_q[i].cyc <= rc - VIS_LAT) begin
        w = log_q[i].word;
        v = 1'b1;
      end
    end
  endtask

  task automatic step(input bit ld, input logic [3:0] opc, input int a, input int b,
                      input logic [4:0] wp, input logic [4:0] rp);
    logic [104:0] ew;
    logic         ev;
    load_en       = ld;
    opcode        = opc;
    operand_a     = a;
    operand_b     = b;
    write_pointer = wp;
    read_pointer  = rp;
    @(posedge clk);
    cyc++;
    if (ld) log_q.push_back('{cyc, wp, mk_word(opc, a, b)});
    @(negedge clk);
    expect_read(cyc, rp, ew, ev);
    check("rd_word", instruction_word, ew);
    check("rd_valid", 105'(rd_valid), 105'(ev));
  endtask

  task automatic idle_read(input logic [4:0] rp);
    step(1'b0, 4'd0, 0, 0, 5'd0, rp);
  endtask

  initial begin
    reset = 1'b1;
    load_en = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
    write_pointer = '0; read_pointer = '0;
    repeat (2) @(negedge clk);
    check("reset_word", instruction_word, 105'd0);
    check("reset_valid", 105'(rd_valid), 105'd0);
    reset = 1'b0;

    idle_read(5'd17);
    check("unwritten_17_valid", 105'(rd_valid), 105'd0);

    // Forwarding window: addr 0 still unwritten at N+1 unless bypass is built in.
    step(1'b1, 4'd4, 10, 4, 5'd0, 5'd5);
    idle_read(5'd0);
`ifdef INSTR_REG_BYPASS_EN
    check("bypass_res", 105'(instruction_word[31:0]), 105'd6);
    check("bypass_valid", 105'(rd_valid), 105'd1);
`else
    check("nobypass_word", instruction_word, 105'd0);
    check("nobypass_valid", 105'(rd_valid), 105'd0);
`endif
    idle_read(5'd0);
    check("sub_res", 105'(instruction_word[31:0]), 105'd6);

    step(1'b1, 4'd3, 7, -3, 5'd4, 5'd0);
    idle_read(5'd4);
    idle_read(5'd4);
    check("add_opc", 105'(instruction_word[99:96]), 105'd3);
    check("add_op_a", 105'(instruction_word[95:64]), 105'd7);
    check("add_op_b", 105'(instruction_word[63:32]), 105'(32'hFFFF_FFFD));
    check("add_res", 105'(instruction_word[31:0]), 105'd4);
    check("add_valid", 105'(rd_valid), 105'd1);

    step(1'b1, 4'd6, 15, 0, 5'd1, 5'd0);
    step(1'b1, 4'd7, -7, 2, 5'd2, 5'd0);
    step(1'b1, 4'd5, 32'h0001_0000, 32'h0001_0000, 5'd3, 5'd0);
    idle_read(5'd1);
    check("div0_res", 105'(instruction_word[31:0]), 105'd0);
    idle_read(5'd2);
    check("mod_neg_res", 105'(instruction_word[31:0]), 105'(32'hFFFF_FFFF));
    idle_read(5'd3);
    check("mult_wrap_res", 105'(instruction_word[31:0]), 105'd0);
    check("mult_wrap_valid", 105'(rd_valid), 105'd1);

    step(1'b1, 4'd1, 5, 0, 5'd31, 5'd0);
    step(1'b1, 4'd2, 0, 9, 5'd31, 5'd0);
    idle_read(5'd31);
    idle_read(5'd31);
    check("overwrite_res", 105'(instruction_word[31:0]), 105'd9);

    for (int n = 0; n < 400; n++) begin
      bit          ld  = ($urandom_range(0, 3) != 0);
      logic [3:0]  opc = 4'($urandom_range(0, 15));
      int          a   = ($urandom_range(0, 1) == 1) ? int'($urandom) : $urandom_range(0, 40) - 20;
      int          b   = ($urandom_range(0, 1) == 1) ? int'($urandom) : $urandom_range(0, 10) - 5;
      logic [4:0]  wp  = 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 31));
      logic [4:0]  rp  = 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 31));
      step(ld, opc, a, b, wp, rp);
    end

    // Mid-cycle reset with a write still in stage 1: it must never reach storage.
    step(1'b1, 4'd1, 123, 0, 5'd9, 5'd9);
    load_en = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midreset_word", instruction_word, 105'd0);
    check("midreset_valid", 105'(rd_valid), 105'd0);
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
    reset   = 1'b0;
    log_q.delete();
    idle_read(5'd9);
    idle_read(5'd9);
    check("midreset_dropped_valid", 105'(rd_valid), 105'd0);
    idle_read(5'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
